// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: N-channel arbiter feeding the single VRAM write port (time-slot or round-robin).
// Latency: a transfer in cycle T appears on addr/dwrite/wr/grant_id in cycle T+1.
// Backpressure: ch_ready is combinational and at most one-hot. Optional macro VRAM_ARB_PRIO0_EN gives ch0 strict priority in round-robin mode.
module vram_write_arbiter #(
   parameter int N_CH     = 4,
   parameter int ADDR_W   = 19,
   parameter int DATA_W   = 16,
   parameter int SLOT_LEN = 64
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     mode,
   input  logic                     frame_sync,
   input  logic [N_CH-1:0]          ch_valid,
   input  logic [N_CH*ADDR_W-1:0]   ch_addr,
   input  logic [N_CH*DATA_W-1:0]   ch_dwrite,
   input  logic [N_CH-1:0]          ch_wr,
   output logic [N_CH-1:0]          ch_ready,
   output logic [ADDR_W-1:0]        addr,
   output logic [DATA_W-1:0]        dwrite,
   output logic                     wr,
   output logic [$clog2(N_CH)-1:0]  grant_id
);

   localparam int ID_W  = $clog2(N_CH);
   localparam int CNT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_dwrite;
   logic              r_wr;
   logic [ID_W-1:0]   r_grant_id;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [CNT_W-1:0]  r_slot_cnt;
   logic [ID_W-1:0]   r_slot_owner;
   logic              r_mode;

   logic [N_CH-1:0]   w_ready;
   logic [ID_W-1:0]   w_gidx;
   logic [ID_W:0]     w_cand;
   logic              w_found;
   logic              w_prio;
   logic              w_xfer;

   // Pick the granted channel: slot owner in time-slot mode, first requester from rr_ptr in round-robin.
   always_comb begin
      w_ready = '0;
      w_gidx  = '0;
      w_cand  = '0;
      w_found = 1'b0;
      w_prio  = 1'b0;
      if (rstn) begin
         if (!r_mode) begin
            // Owner gets ready regardless of valid so slot timing stays deterministic.
            w_ready[r_slot_owner] = 1'b1;
            w_gidx                = r_slot_owner;
         end else begin
`ifdef VRAM_ARB_PRIO0_EN
            if (ch_valid[0]) begin
               w_found = 1'b1;
               w_prio  = 1'b1;
            end
`endif
            for (int off = 0; off < N_CH; off++) begin
               w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(off);
               if (w_cand >= (ID_W+1)'(N_CH)) begin
                  w_cand = w_cand - (ID_W+1)'(N_CH);
               end
               if (!w_found && ch_valid[w_cand[ID_W-1:0]]) begin
                  w_found = 1'b1;
                  w_gidx  = w_cand[ID_W-1:0];
               end
            end
            if (w_found) begin
               w_ready[w_gidx] = 1'b1;
            end
         end
      end
   end

   assign w_xfer   = |(ch_valid & w_ready);
   assign ch_ready = w_ready;

   // Register the VRAM command and advance slot / round-robin state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_addr       <= '0;
         r_dwrite     <= '0;
         r_wr         <= 1'b0;
         r_grant_id   <= '0;
         r_rr_ptr     <= '0;
         r_slot_cnt   <= '0;
         r_slot_owner <= '0;
         r_mode       <= mode;
      end else begin
         r_wr <= w_xfer & ch_wr[w_gidx];
         if (w_xfer) begin
            r_addr     <= ch_addr[w_gidx*ADDR_W +: ADDR_W];
            r_dwrite   <= ch_dwrite[w_gidx*DATA_W +: DATA_W];
            r_grant_id <= w_gidx;
         end
         r_mode <= mode;
         if (mode != r_mode) begin
            // Fresh start for whichever mode takes over next cycle.
            r_slot_cnt   <= '0;
            r_slot_owner <= '0;
            r_rr_ptr     <= '0;
         end else begin
            if (frame_sync) begin
               r_slot_cnt   <= '0;
               r_slot_owner <= '0;
            end else if (r_slot_cnt == CNT_W'(SLOT_LEN-1)) begin
               r_slot_cnt   <= '0;
               r_slot_owner <= (r_slot_owner == ID_W'(N_CH-1)) ? '0 : r_slot_owner + ID_W'(1);
            end else begin
               r_slot_cnt   <= r_slot_cnt + CNT_W'(1);
            end
            // A priority grant to ch0 leaves the rotation where it was.
            if (r_mode && w_xfer && !w_prio) begin
               r_rr_ptr <= (w_gidx == ID_W'(N_CH-1)) ? '0 : w_gidx + ID_W'(1);
            end
         end
      end
   end

   assign addr     = r_addr;
   assign dwrite   = r_dwrite;
   assign wr       = r_wr;
   assign grant_id = r_grant_id;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter (N_CH=4, SLOT_LEN=4): directed vectors, scoreboard queue plus monitor.
// Expected writes are queued with the cycle they must appear in; the monitor pops them after each edge.
// Build with VRAM_ARB_PRIO0_EN defined to exercise the ch0 priority variant.
module tb_vram_write_arbiter;

   localparam int N_CH = 4;
   localparam int AW   = 19;
   localparam int DW   = 16;

   logic              clk = 1'b0;
   logic              rstn;
   logic              mode;
   logic              frame_sync;
   logic [N_CH-1:0]   ch_valid;
   logic [N_CH*AW-1:0] ch_addr;
   logic [N_CH*DW-1:0] ch_dwrite;
   logic [N_CH-1:0]   ch_wr;
   logic [N_CH-1:0]   ch_ready;
   logic [AW-1:0]     addr;
   logic [DW-1:0]     dwrite;
   logic              wr;
   logic [1:0]        grant_id;

   typedef struct {
      int          cyc;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [1:0]  g;
   } exp_t;

   exp_t   q[$];
   exp_t   m_e;
   int     checks = 0;
   int     errors = 0;
   int     cyc    = 0;
   int     seq    = 0;
   logic   fix_en = 1'b0;
   logic [AW-1:0] last_addr;
   logic [DW-1:0] last_data;

   vram_write_arbiter #(.N_CH(N_CH), .ADDR_W(AW), .DATA_W(DW), .SLOT_LEN(4)) dut (
      .clk(clk), .rstn(rstn), .mode(mode), .frame_sync(frame_sync),
      .ch_valid(ch_valid), .ch_addr(ch_addr), .ch_dwrite(ch_dwrite), .ch_wr(ch_wr),
      .ch_ready(ch_ready), .addr(addr), .dwrite(dwrite), .wr(wr), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: after every edge, either the queued write is due now or no write may appear.
   always @(posedge clk) begin
      #1;
      if (q.size() > 0 && q[0].cyc == cyc) begin
         m_e = q.pop_front();
         chk("mon_wr", 32'(wr), 32'd1);
         chk("mon_addr", 32'(addr), 32'(m_e.a));
         chk("mon_dwrite", 32'(dwrite), 32'(m_e.d));
         chk("mon_grant_id", 32'(grant_id), 32'(m_e.g));
      end else if (wr === 1'b1) begin
         chk("mon_unexpected_wr", 32'(wr), 32'd0);
      end
   end

   // One cycle of stimulus, entered and left at a negedge; er is the hand-computed ch_ready.
   task automatic drive(input logic md, input logic fs, input logic [3:0] v,
                        input logic [3:0] w, input logic [3:0] er, input string nm);
      exp_t e;
      seq++;
      mode       = md;
      frame_sync = fs;
      ch_valid   = v;
      ch_wr      = w;
      for (int ch = 0; ch < N_CH; ch++) begin
         ch_addr[ch*AW +: AW]   = AW'(ch*32'h10000 + seq);
         ch_dwrite[ch*DW +: DW] = DW'(seq*8 + ch) ^ 16'h5A00;
      end
      if (fix_en) begin
         ch_addr[3*AW +: AW]   = 19'h12345;
         ch_dwrite[3*DW +: DW] = 16'hBEEF;
      end
      #2;
      chk(nm, 32'(ch_ready), 32'(er));
      if ((er & v & w) != 4'b0000) begin
         for (int k = 0; k < N_CH; k++) begin
            if (er[k]) begin
               e.g = 2'(k);
               e.a = ch_addr[k*AW +: AW];
               e.d = ch_dwrite[k*DW +: DW];
            end
         end
         e.cyc = cyc + 1;
         last_addr = e.a;
         last_data = e.d;
         q.push_back(e);
      end
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rstn = 1'b0; mode = 1'b0; frame_sync = 1'b0;
      ch_valid = '0; ch_wr = '0; ch_addr = '0; ch_dwrite = '0;
      @(negedge clk);

      // Reset held with every channel requesting.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 4'b1111, 4'b1111, 4'b0000, "rst_ready");
         chk("rst_wr", 32'(wr), 32'd0);
      end
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_dwrite", 32'(dwrite), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      rstn = 1'b1;

      // Time-slot, all valid: 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001 x4.
      for (int i = 0; i < 20; i++)
         drive(1'b0, 1'b0, 4'b1111, 4'b1111, 4'(1 << ((i/4) % 4)), "ts_all_ready");

      // Owner is ch1 here; frame_sync with no requests restarts at ch0.
      drive(1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0010, "ts_fs_idle");
      // Only ch2 valid: writes only during its slot (cycles 8..11), 12 idle cycles.
      for (int i = 0; i < 16; i++)
         drive(1'b0, 1'b0, 4'b0100, 4'b1111, 4'(1 << (i/4)), "ts_ch2_ready");
      chk("ts_hold_wr", 32'(wr), 32'd0);
      chk("ts_hold_addr", 32'(addr), 32'(last_addr));
      chk("ts_hold_dwrite", 32'(dwrite), 32'(last_data));
      chk("ts_hold_grant_id", 32'(grant_id), 32'd2);

      // Bring owner 1 to its last slot cycle, then frame_sync on the wrap.
      for (int i = 0; i < 7; i++)
         drive(1'b0, 1'b0, 4'b1111, 4'b1111, (i < 4) ? 4'b0001 : 4'b0010, "ts_pre_wrap");
      drive(1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0010, "ts_fs_wrap");
      for (int i = 0; i < 4; i++)
         drive(1'b0, 1'b0, 4'b1111, 4'b1111, 4'b0001, "ts_after_fs");
      drive(1'b0, 1'b0, 4'b1111, 4'b1111, 4'b0010, "ts_after_fs_next");

      // Switch to round-robin: this cycle still follows the slot owner (ch1).
      drive(1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0010, "mode_switch");

`ifdef VRAM_ARB_PRIO0_EN
      drive(1'b1, 1'b0, 4'b0100, 4'b1111, 4'b0100, "prio_setup");      // rr_ptr -> 3
      for (int i = 0; i < 4; i++)
         drive(1'b1, 1'b0, 4'b0101, 4'b1111, 4'b0001, "prio_ch0");
      drive(1'b1, 1'b0, 4'b1100, 4'b1111, 4'b1000, "prio_ptr_kept");  // rr_ptr still 3
`else
      // Round-robin all valid: 0,1,2,3; then ch1 dropped: 0,2,3,0,2.
      for (int i = 0; i < 4; i++)
         drive(1'b1, 1'b0, 4'b1111, 4'b1111, 4'(1 << i), "rr_all");
      drive(1'b1, 1'b0, 4'b1101, 4'b1111, 4'b0001, "rr_drop1_a");
      drive(1'b1, 1'b0, 4'b1101, 4'b1111, 4'b0100, "rr_drop1_b");
      drive(1'b1, 1'b0, 4'b1101, 4'b1111, 4'b1000, "rr_drop1_c");
      drive(1'b1, 1'b0, 4'b1101, 4'b1111, 4'b0001, "rr_drop1_d");
      drive(1'b1, 1'b0, 4'b1101, 4'b1111, 4'b0100, "rr_drop1_e");
`endif

      // No requester: nothing ready.
      drive(1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, "rr_idle");
      chk("rr_idle_wr", 32'(wr), 32'd0);

      // ch3 fixed command appears unchanged one cycle later.
      fix_en = 1'b1;
      drive(1'b1, 1'b0, 4'b1000, 4'b1000, 4'b1000, "rr_ch3_ready");
      fix_en = 1'b0;
      chk("rr_ch3_addr", 32'(addr), 32'h12345);
      chk("rr_ch3_dwrite", 32'(dwrite), 32'hBEEF);
      chk("rr_ch3_wr", 32'(wr), 32'd1);
      chk("rr_ch3_grant_id", 32'(grant_id), 32'd3);

      // ch_wr=0 transfer: consumed (rr_ptr -> 2) but wr stays low.
      drive(1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0010, "rr_nowr_ready");
      chk("rr_nowr_wr", 32'(wr), 32'd0);
      chk("rr_nowr_grant_id", 32'(grant_id), 32'd1);
      drive(1'b1, 1'b0, 4'b0110, 4'b1111, 4'b0100, "rr_ptr_after_nowr");

      // Reset mid-operation drops the registered command.
      rstn = 1'b0;
      drive(1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0000, "rst_mid_ready");
      chk("rst_mid_wr", 32'(wr), 32'd0);
      chk("rst_mid_addr", 32'(addr), 32'd0);
      chk("rst_mid_grant_id", 32'(grant_id), 32'd0);
      rstn = 1'b1;
      drive(1'b1, 1'b0, 4'b1110, 4'b1111, 4'b0010, "rst_mid_rr_ptr0");

      drive(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, "tail_idle");
      drive(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, "tail_idle");
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
